// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op encodings,
// FSM states and op-classification helpers.
`timescale 1ns/1ps
package muldiv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_FIX,
    ST_DONE
  } state_e;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MADD  = 3'd4;
  localparam logic [2:0] OP_MADDU = 3'd5;

  function automatic logic is_signed_op(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_DIV) || (op == OP_MADD);
  endfunction

  function automatic logic is_div_op(input logic [2:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic is_madd_op(input logic [2:0] op);
    return (op == OP_MADD) || (op == OP_MADDU);
  endfunction

  function automatic logic is_reserved_op(input logic [2:0] op);
    return op[2:1] == 2'b11;
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration on the {hi,lo} working pair: shift-add for multiply,
// restoring trial-subtract for divide. Operands are unsigned magnitudes.
`timescale 1ns/1ps
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             i_div,
  input  logic [WIDTH-1:0] i_hi,
  input  logic [WIDTH-1:0] i_lo,
  input  logic [WIDTH-1:0] i_opnd,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);

  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_tmp;
  logic [WIDTH-1:0] w_rem;
  logic             w_ge;

  always_comb begin
    w_sum = {1'b0, i_hi} + (i_lo[0] ? {1'b0, i_opnd} : '0);
    w_tmp = {i_hi, i_lo[WIDTH-1]};
    w_ge  = w_tmp >= {1'b0, i_opnd};
    // partial remainder stays below the divisor, so the difference fits WIDTH bits
    w_rem = w_tmp[WIDTH-1:0] - i_opnd;
    if (i_div) begin
      o_hi = w_ge ? w_rem : w_tmp[WIDTH-1:0];
      o_lo = {i_lo[WIDTH-2:0], w_ge};
    end else begin
      o_hi = w_sum[WIDTH:1];
      o_lo = {w_sum[0], i_lo[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/iter_muldiv_hilo.sv
// Multi-cycle multiply/divide/MAC unit with architectural HI/LO registers,
// valid/ready handshake and kill. UNROLL radix-2 steps are chained per clock.
`timescale 1ns/1ps
module iter_muldiv_hilo
  import muldiv_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int UNROLL = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [WIDTH-1:0] in_A,
  input  logic [WIDTH-1:0] in_B,
  input  logic             kill,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int N  = WIDTH / UNROLL;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  state_e           r_state;
  logic             r_in_ready;
  logic             r_out_valid;
  logic             r_dbz;
  logic             r_dbz_pend;
  logic             r_neg_q;
  logic             r_neg_r;
  logic [2:0]       r_op;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_p_hi;
  logic [WIDTH-1:0] r_p_lo;
  logic [WIDTH-1:0] r_opnd;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;

  logic             w_a_neg;
  logic             w_b_neg;
  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;
  logic             w_in_div;
  logic             w_is_div;
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_res;
  logic [WIDTH-1:0] w_fix_hi;
  logic [WIDTH-1:0] w_fix_lo;
  logic [WIDTH-1:0] w_chain_hi [UNROLL+1];
  logic [WIDTH-1:0] w_chain_lo [UNROLL+1];

  assign in_ready    = r_in_ready;
  assign out_valid   = r_out_valid;
  assign div_by_zero = r_dbz;
  assign hi          = r_hi;
  assign lo          = r_lo;

  assign w_a_neg  = is_signed_op(in_op) & in_A[WIDTH-1];
  assign w_b_neg  = is_signed_op(in_op) & in_B[WIDTH-1];
  assign w_a_mag  = w_a_neg ? -in_A : in_A;
  assign w_b_mag  = w_b_neg ? -in_B : in_B;
  assign w_in_div = is_div_op(in_op);
  assign w_is_div = is_div_op(r_op);

  assign w_chain_hi[0] = r_p_hi;
  assign w_chain_lo[0] = r_p_lo;

  for (genvar g = 0; g < UNROLL; g++) begin : g_step
    muldiv_step #(.WIDTH(WIDTH)) u_step (
      .i_div  (w_is_div),
      .i_hi   (w_chain_hi[g]),
      .i_lo   (w_chain_lo[g]),
      .i_opnd (r_opnd),
      .o_hi   (w_chain_hi[g+1]),
      .o_lo   (w_chain_lo[g+1])
    );
  end

  always_comb begin
    w_prod   = {r_p_hi, r_p_lo};
    w_res    = (r_neg_q ? -w_prod : w_prod) + (is_madd_op(r_op) ? {r_hi, r_lo} : '0);
    w_fix_hi = w_res[2*WIDTH-1:WIDTH];
    w_fix_lo = w_res[WIDTH-1:0];
    if (r_dbz_pend) begin
      w_fix_hi = r_p_hi;
      w_fix_lo = '1;
    end else if (w_is_div) begin
      w_fix_lo = r_neg_q ? -r_p_lo : r_p_lo;
      w_fix_hi = r_neg_r ? -r_p_hi : r_p_hi;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_dbz       <= 1'b0;
      r_dbz_pend  <= 1'b0;
      r_neg_q     <= 1'b0;
      r_neg_r     <= 1'b0;
      r_op        <= '0;
      r_cnt       <= '0;
      r_p_hi      <= '0;
      r_p_lo      <= '0;
      r_opnd      <= '0;
      r_hi        <= '0;
      r_lo        <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid && !kill) begin
            r_in_ready <= 1'b0;
            r_op       <= in_op;
            r_dbz_pend <= 1'b0;
            if (is_reserved_op(in_op)) begin
              r_state     <= ST_DONE;
              r_out_valid <= 1'b1;
              r_dbz       <= 1'b0;
            end else if (w_in_div && in_B == '0) begin
              // divide-by-zero bypasses iteration; FIX forwards the raw dividend
              r_state    <= ST_FIX;
              r_dbz_pend <= 1'b1;
              r_p_hi     <= in_A;
            end else begin
              r_state <= ST_CALC;
              r_p_hi  <= '0;
              r_p_lo  <= w_in_div ? w_a_mag : w_b_mag;
              r_opnd  <= w_in_div ? w_b_mag : w_a_mag;
              r_neg_q <= w_a_neg ^ w_b_neg;
              r_neg_r <= w_a_neg;
              r_cnt   <= CW'(N - 1);
            end
          end
        end
        ST_CALC: begin
          if (kill) begin
            r_state    <= ST_IDLE;
            r_in_ready <= 1'b1;
          end else begin
            r_p_hi <= w_chain_hi[UNROLL];
            r_p_lo <= w_chain_lo[UNROLL];
            if (r_cnt == '0) begin
              r_state <= ST_FIX;
            end else begin
              r_cnt <= r_cnt - 1'b1;
            end
          end
        end
        ST_FIX: begin
          if (kill) begin
            r_state    <= ST_IDLE;
            r_in_ready <= 1'b1;
          end else begin
            r_hi        <= w_fix_hi;
            r_lo        <= w_fix_lo;
            r_dbz       <= r_dbz_pend;
            r_out_valid <= 1'b1;
            r_state     <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_dbz       <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_state    <= ST_IDLE;
          r_in_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_iter_muldiv_hilo.sv
// Scoreboard bench for iter_muldiv_hilo: expected HI/LO results are computed
// with plain wide arithmetic at issue time and checked by an independent monitor.
`timescale 1ns/1ps
module tb_iter_muldiv_hilo;
  import muldiv_pkg::*;

  parameter int UNROLL = 1;
  localparam int W = 32;
  localparam int N = W / UNROLL;
  localparam logic [W-1:0] MINV = {1'b1, {(W-1){1'b0}}};

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dbz;
    int           acc;
    int           lat;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [2:0]   in_op = '0;
  logic [W-1:0] in_A = '0;
  logic [W-1:0] in_B = '0;
  logic         kill = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic         div_by_zero;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  exp_t         sb[$];
  exp_t         mon_e;
  int           n_chk = 0;
  int           n_fail = 0;
  int           cyc = 0;
  logic         rdy_rand = 1'b0;
  logic         mon_hold = 1'b0;
  logic [W-1:0] mon_hi = '0;
  logic [W-1:0] mon_lo = '0;
  logic [W-1:0] m_hi = '0;
  logic [W-1:0] m_lo = '0;

  iter_muldiv_hilo #(.WIDTH(W), .UNROLL(UNROLL)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_op       (in_op),
    .in_A        (in_A),
    .in_B        (in_B),
    .kill        (kill),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .div_by_zero (div_by_zero),
    .hi          (hi),
    .lo          (lo)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference: architectural result from plain integer arithmetic.
  task automatic ref_model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] hi0, input logic [W-1:0] lo0,
                           output logic [W-1:0] hi1, output logic [W-1:0] lo1,
                           output logic dbz, output int lat);
    logic signed [2*W-1:0] sa, sb_, sp;
    logic [2*W-1:0]        up;
    dbz = 1'b0;
    hi1 = hi0;
    lo1 = lo0;
    lat = N + 1;
    sa  = $signed(a);
    sb_ = $signed(b);
    case (op)
      OP_MULT:  begin sp = sa * sb_; {hi1, lo1} = sp; end
      OP_MULTU: begin up = {{W{1'b0}}, a} * {{W{1'b0}}, b}; {hi1, lo1} = up; end
      OP_MADD:  begin sp = sa * sb_; {hi1, lo1} = {hi0, lo0} + sp; end
      OP_MADDU: begin up = {{W{1'b0}}, a} * {{W{1'b0}}, b}; {hi1, lo1} = {hi0, lo0} + up; end
      OP_DIV, OP_DIVU: begin
        if (b == '0) begin
          hi1 = a; lo1 = '1; dbz = 1'b1; lat = 1;
        end else if (op == OP_DIV && a == MINV && b == '1) begin
          lo1 = MINV; hi1 = '0;
        end else if (op == OP_DIV) begin
          lo1 = W'($signed(a) / $signed(b));
          hi1 = W'($signed(a) % $signed(b));
        end else begin
          lo1 = a / b;
          hi1 = a % b;
        end
      end
      default: lat = 0;
    endcase
  endtask

  task automatic wait_ready();
    int t = 0;
    while (!in_ready && t < 4 * N + 40) begin
      @(posedge clk); #1;
      t++;
    end
    chk("ready_timeout", 64'(in_ready), 64'(1));
  endtask

  task automatic accept(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    wait_ready();
    in_op = op; in_A = a; in_B = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic do_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    accept(op, a, b);
    ref_model(op, a, b, m_hi, m_lo, e.hi, e.lo, e.dbz, e.lat);
    m_hi  = e.hi;
    m_lo  = e.lo;
    e.acc = cyc;
    sb.push_back(e);
  endtask

  // Kill lands on the edge dly+1 cycles after the accept edge.
  task automatic kill_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input int dly);
    accept(op, a, b);
    repeat (dly) begin @(posedge clk); #1; end
    kill = 1'b1;
    @(posedge clk); #1;
    kill = 1'b0;
    chk("kill_in_ready", 64'(in_ready), 64'(1));
  endtask

  function automatic logic [W-1:0] rnd_opnd();
    case ($urandom_range(0, 7))
      0: return '0;
      1: return W'(1);
      2: return '1;
      3: return MINV;
      4: return W'($urandom_range(0, 15));
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    forever begin
      @(posedge clk); #1;
      if (rdy_rand) out_ready = 1'($urandom_range(0, 1));
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      mon_hold = 1'b0;
      mon_hi   = '0;
      mon_lo   = '0;
    end else begin
      if (out_valid && !mon_hold) begin
        if (sb.size() == 0) begin
          chk("spurious_out_valid", 64'(out_valid), 64'(0));
        end else begin
          mon_e = sb.pop_front();
          chk("hi", 64'(hi), 64'(mon_e.hi));
          chk("lo", 64'(lo), 64'(mon_e.lo));
          chk("div_by_zero", 64'(div_by_zero), 64'(mon_e.dbz));
          chk("latency", 64'(cyc - mon_e.acc), 64'(mon_e.lat));
          mon_hi = mon_e.hi;
          mon_lo = mon_e.lo;
        end
        mon_hold = 1'b1;
      end else begin
        chk("hi_stable", 64'(hi), 64'(mon_hi));
        chk("lo_stable", 64'(lo), 64'(mon_lo));
      end
      if (out_valid && out_ready) mon_hold = 1'b0;
    end
  end

  initial begin
    int kdly;
    int t;
    logic [2:0] op;
    kdly = (N > 10) ? 9 : N / 2;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'(1));
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_dbz", 64'(div_by_zero), 64'(0));
    chk("rst_hi", 64'(hi), 64'(0));
    chk("rst_lo", 64'(lo), 64'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;

    do_op(OP_MULT, -W'(3), W'(7));
    do_op(OP_MULTU, '1, '1);
    do_op(OP_DIV, -W'(7), W'(2));
    do_op(OP_DIVU, W'(100), W'(7));
    do_op(OP_DIV, W'(5), '0);
    do_op(OP_MULTU, W'(1), W'(1));
    do_op(OP_MADD, -W'(2), W'(3));
    do_op(OP_DIV, MINV, '1);
    do_op(OP_DIV, W'(7), -W'(2));
    do_op(OP_DIVU, '1, '0);
    do_op(3'd6, W'(11), W'(12));
    do_op(OP_MADDU, '1, '1);

    kill_op(OP_MULT, W'(123), W'(456), kdly);
    kill_op(OP_DIVU, W'(9), W'(4), N);
    kill_op(OP_DIV, W'(5), '0, 0);

    wait_ready();
    in_op = OP_MULT; in_A = W'(3); in_B = W'(3);
    in_valid = 1'b1; kill = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; kill = 1'b0;
    chk("kill_idle_no_accept", 64'(in_ready), 64'(1));

    out_ready = 1'b0;
    do_op(OP_MULT, -W'(5), W'(6));
    t = 0;
    while (!out_valid && t < N + 10) begin @(posedge clk); #1; t++; end
    chk("done_timeout", 64'(out_valid), 64'(1));
    kill = 1'b1;
    @(posedge clk); #1;
    kill = 1'b0;
    chk("kill_done_hold", 64'(out_valid), 64'(1));
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("done_release", 64'(in_ready), 64'(1));

    accept(OP_MULTU, W'(77), W'(88));
    repeat (5) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    sb.delete();
    m_hi = '0;
    m_lo = '0;
    #1;
    chk("midrst_hi", 64'(hi), 64'(0));
    chk("midrst_lo", 64'(lo), 64'(0));
    chk("midrst_in_ready", 64'(in_ready), 64'(1));
    chk("midrst_out_valid", 64'(out_valid), 64'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;

    rdy_rand = 1'b1;
    for (int i = 0; i < 80; i++) begin
      op = 3'($urandom_range(0, 7));
      do_op(op, rnd_opnd(), rnd_opnd());
      if ($urandom_range(0, 9) == 0)
        kill_op(OP_MULTU, rnd_opnd(), rnd_opnd(), $urandom_range(0, N - 1));
    end

    rdy_rand = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b1;
    t = 0;
    while ((sb.size() != 0 || mon_hold) && t < 4 * N + 40) begin @(posedge clk); #1; t++; end
    chk("drain", 64'(sb.size()), 64'(0));
    repeat (3) @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
